julia_fb_render_ctrl: RTL and testbench

//  Parametrised successor of the Julia framebuffer controller. Scans a frame pixel by pixel, sends complex coordinates to the julia

---
 rtl/julia_fb_render_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_julia_fb_render_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/julia_fb_render_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : julia_fb_render_ctrl
//  Brief    : Julia framebuffer render controller with pan/zoom/invert.
//             Feeds coordinates to the engine, quantises results into the
//             frame BRAM and drives gray RGB from the display read port.
//  Revision : 1.0  initial release
// ============================================================================
module julia_fb_render_ctrl #(
    parameter int          H_RES    = 1280,
    parameter int          V_RES    = 720,
    parameter int          PIX_W    = 4,
    parameter int          ITER_W   = 9,
    parameter int          MAX_ITER = 256,
    parameter int          ZOOM_LV  = 4,
    parameter logic [31:0] RE_HALF  = 32'h0004_0000,
    parameter logic [31:0] IM_HALF  = 32'h0002_4000,
    parameter int          AW       = 20,
    localparam int         ZW       = (ZOOM_LV > 1) ? $clog2(ZOOM_LV) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        btn,
    input  logic              mode,
    output logic              c_change,
    output logic              eng_req_valid,
    input  logic              eng_req_ready,
    output logic [31:0]       eng_x_com,
    output logic [31:0]       eng_y_com,
    input  logic              eng_res_valid,
    input  logic [ITER_W-1:0] eng_res_iter,
    output logic              bram_we,
    output logic [AW-1:0]     bram_waddr,
    output logic [PIX_W-1:0]  bram_wdata,
    input  logic [15:0]       sx,
    input  logic [15:0]       sy,
    output logic [AW-1:0]     bram_raddr,
    input  logic [PIX_W-1:0]  bram_rdata,
    output logic [7:0]        o_red,
    output logic [7:0]        o_green,
    output logic [7:0]        o_blue,
    output logic              frame_done,
    output logic [ZW-1:0]     zoom_level
);

    localparam logic signed [31:0] C_RE_HALF = RE_HALF;
    localparam logic signed [31:0] C_IM_HALF = IM_HALF;
    localparam logic signed [31:0] C_STEP_X  = 32'((64'(RE_HALF) * 64'd2) / 64'(H_RES - 1));
    localparam logic signed [31:0] C_STEP_Y  = 32'((64'(IM_HALF) * 64'd2) / 64'(V_RES - 1));
    localparam logic [ZW-1:0]      C_ZMAX    = ZW'(ZOOM_LV - 1);
    localparam int                 C_QSH     = $clog2(MAX_ITER) - PIX_W;
    localparam int                 C_REP     = (8 + PIX_W - 1) / PIX_W;
    localparam logic [15:0]        C_PX_LAST = 16'(H_RES - 1);
    localparam logic [15:0]        C_PY_LAST = 16'(V_RES - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    function automatic logic signed [31:0] f_clamp(input logic signed [32:0] v,
                                                   input logic signed [31:0] lim);
        logic signed [32:0] hi;
        hi = 33'(lim);
        if (v > hi)
            return lim;
        else if (v < -hi)
            return -lim;
        return v[31:0];
    endfunction

    // ---------------- button synchroniser and press detect ----------------
    logic [6:0] r_btn_s1, r_btn_s2, r_btn_d;
    logic [6:0] w_press;
    logic       w_any_press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_btn_d  <= '0;
        end else begin
            r_btn_s1 <= ~btn;
            r_btn_s2 <= r_btn_s1;
            r_btn_d  <= r_btn_s2;
        end
    end

    assign w_press     = r_btn_s2 & ~r_btn_d;
    assign w_any_press = |w_press;

    // ---------------- view registers ----------------
    logic [ZW-1:0]       r_zoom, w_zoom_next;
    logic signed [31:0]  r_cx, r_cy, w_cx_next, w_cy_next;
    logic signed [31:0]  w_dx, w_dy, w_step_x, w_step_y, w_x0, w_y0;

    assign w_dx     = C_RE_HALF >>> (32'(r_zoom) + 32'd2);
    assign w_dy     = C_IM_HALF >>> (32'(r_zoom) + 32'd2);
    assign w_step_x = C_STEP_X >>> r_zoom;
    assign w_step_y = C_STEP_Y >>> r_zoom;
    assign w_x0     = r_cx - (C_RE_HALF >>> r_zoom);
    assign w_y0     = r_cy + (C_IM_HALF >>> r_zoom);

    // Only the highest-priority view press of a cycle takes effect.
    always_comb begin
        w_zoom_next = r_zoom;
        w_cx_next   = r_cx;
        w_cy_next   = r_cy;
        if (w_press[1]) begin
            if (r_zoom != C_ZMAX)
                w_zoom_next = r_zoom + 1'b1;
        end else if (w_press[2]) begin
            if (r_zoom != '0)
                w_zoom_next = r_zoom - 1'b1;
        end else if (w_press[3]) begin
            w_cx_next = f_clamp(33'(r_cx) - 33'(w_dx), C_RE_HALF);
        end else if (w_press[4]) begin
            w_cx_next = f_clamp(33'(r_cx) + 33'(w_dx), C_RE_HALF);
        end else if (w_press[5]) begin
            w_cy_next = f_clamp(33'(r_cy) + 33'(w_dy), C_IM_HALF);
        end else if (w_press[6]) begin
            w_cy_next = f_clamp(33'(r_cy) - 33'(w_dy), C_IM_HALF);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_zoom <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
        end else begin
            r_zoom <= w_zoom_next;
            r_cx   <= w_cx_next;
            r_cy   <= w_cy_next;
        end
    end

    // ---------------- render FSM ----------------
    state_t             r_state;
    logic               r_req_valid, r_we, r_frame_done, r_c_change, r_pend;
    logic signed [31:0] r_x, r_y;
    logic [15:0]        r_px, r_py;
    logic [AW-1:0]      r_addr;
    logic [PIX_W-1:0]   r_wdata, w_quant;

    assign w_quant = ({1'b0, eng_res_iter} >= (ITER_W + 1)'(MAX_ITER)) ? '1
                   : PIX_W'(eng_res_iter >> C_QSH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_INIT;
            r_req_valid  <= 1'b0;
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            r_c_change   <= 1'b0;
            r_pend       <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            r_c_change   <= w_press[0];
            if (w_any_press)
                r_pend <= 1'b1;
            case (r_state)
                S_INIT: begin
                    r_x         <= w_x0;
                    r_y         <= w_y0;
                    r_req_valid <= 1'b1;
                    r_state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (eng_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eng_res_valid) begin
                        if (r_pend) begin
                            // Restart: drop this result and rescan from the top-left.
                            if (!w_any_press)
                                r_pend <= 1'b0;
                            r_px        <= '0;
                            r_py        <= '0;
                            r_addr      <= '0;
                            r_x         <= w_x0;
                            r_y         <= w_y0;
                            r_req_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else begin
                            r_wdata <= w_quant;
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_px == C_PX_LAST) begin
                        r_px <= '0;
                        r_x  <= w_x0;
                        if (r_py == C_PY_LAST) begin
                            r_py         <= '0;
                            r_addr       <= '0;
                            r_y          <= w_y0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_py   <= r_py + 16'd1;
                            r_addr <= r_addr + 1'b1;
                            r_y    <= r_y - w_step_y;
                        end
                    end else begin
                        r_px   <= r_px + 16'd1;
                        r_addr <= r_addr + 1'b1;
                        r_x    <= r_x + w_step_x;
                    end
                    r_req_valid <= 1'b1;
                    r_state     <= S_ISSUE;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    // ---------------- display read path ----------------
    logic          w_vis, r_vis_d;
    logic [7:0]    w_gray, r_rgb;
    logic [AW-1:0] w_raddr_lin;

    assign w_vis       = (sx < 16'(H_RES)) && (sy < 16'(V_RES));
    assign w_raddr_lin = AW'(sx) + AW'(sy) * AW'(H_RES);
    assign bram_raddr  = w_vis ? w_raddr_lin : '0;
    assign w_gray      = 8'({C_REP{bram_rdata}} >> (C_REP * PIX_W - 8));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vis_d <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_vis_d <= w_vis;
            r_rgb   <= r_vis_d ? (mode ? ~w_gray : w_gray) : 8'h00;
        end
    end

    assign c_change      = r_c_change;
    assign eng_req_valid = r_req_valid;
    assign eng_x_com     = r_x;
    assign eng_y_com     = r_y;
    assign bram_we       = r_we;
    assign bram_waddr    = r_addr;
    assign bram_wdata    = r_wdata;
    assign frame_done    = r_frame_done;
    assign zoom_level    = r_zoom;
    assign o_red         = r_rgb;
    assign o_green       = r_rgb;
    assign o_blue        = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_julia_fb_render_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_julia_fb_render_ctrl
//  Brief    : Directed self-checking bench for julia_fb_render_ctrl (8x4 frame).
//  Revision : 1.0  initial release
// ============================================================================
module tb_julia_fb_render_ctrl;

    // 8x4 frame: STEP_X = 0x80000/7 = 0x12492, STEP_Y = 0x48000/3 = 0x18000
    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  btn;
    logic        mode;
    logic        c_change, eng_req_valid, eng_req_ready, eng_res_valid;
    logic [31:0] eng_x_com, eng_y_com;
    logic [8:0]  eng_res_iter;
    logic        bram_we, frame_done;
    logic [19:0] bram_waddr, bram_raddr;
    logic [3:0]  bram_wdata, bram_rdata;
    logic [15:0] sx, sy;
    logic [7:0]  o_red, o_green, o_blue;
    logic [1:0]  zoom_level;

    always #5 clk = ~clk;

    julia_fb_render_ctrl #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst(rst), .btn(btn), .mode(mode), .c_change(c_change),
        .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
        .eng_x_com(eng_x_com), .eng_y_com(eng_y_com),
        .eng_res_valid(eng_res_valid), .eng_res_iter(eng_res_iter),
        .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
        .sx(sx), .sy(sy), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .frame_done(frame_done), .zoom_level(zoom_level)
    );

    int errors = 0;
    int checks = 0;
    int wr_count = 0, fd_count = 0, cc_count = 0, hs_count = 0, f_count = 0, seq_count = 0;
    logic [3:0]  last_wdata;
    logic [19:0] last_waddr;
    logic [31:0] last_req_x, last_req_y;
    logic [31:0] reqx [0:63];
    logic [31:0] reqy [0:63];
    bit          eng_auto;
    int          eng_cnt;
    logic [8:0]  eng_iter_val;

    // One clock: observe at the falling edge, then run the ideal engine model.
    task automatic cycle();
        @(negedge clk);
        if (bram_we) begin
            if (bram_waddr == 20'(wr_count)) seq_count++;
            if (bram_wdata == 4'hF) f_count++;
            wr_count++;
            last_wdata = bram_wdata;
            last_waddr = bram_waddr;
        end
        if (frame_done) fd_count++;
        if (c_change) cc_count++;
        if (eng_req_valid && eng_req_ready) begin
            if (hs_count < 64) begin
                reqx[hs_count] = eng_x_com;
                reqy[hs_count] = eng_y_com;
            end
            hs_count++;
            last_req_x = eng_x_com;
            last_req_y = eng_y_com;
        end
        if (eng_auto) begin
            eng_res_valid = 1'b0;
            if (eng_cnt != 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_res_valid = 1'b1;
                    eng_res_iter  = eng_iter_val;
                end
            end else if (eng_req_valid && eng_req_ready) begin
                eng_cnt = 2;
            end
        end
    endtask

    task automatic press(input int b);
        btn[b] = 1'b0;
        repeat (3) cycle();
        btn = 7'h7F;
        repeat (3) cycle();
    endtask

    // Manual engine: deliver one result while the FSM waits, then let it re-handshake.
    task automatic flush();
        eng_res_iter  = 9'd100;
        eng_res_valid = 1'b1;
        cycle();
        eng_res_valid = 1'b0;
        cycle();
    endtask

    task automatic pixel_with(input logic [8:0] iter, input logic [3:0] exp);
        int base;
        base = wr_count;
        eng_iter_val = iter;
        for (int i = 0; i < 30 && wr_count == base; i++) cycle();
        checks++; if (wr_count == base) begin errors++; $display("FAIL quant_timeout iter=%0d: no write", iter); end
        checks++; if (last_wdata !== exp) begin errors++; $display("FAIL quant iter=%0d: got %h want %h", iter, last_wdata, exp); end
    endtask

    task automatic test_reset();
        rst = 1'b0; btn = 7'h7F; mode = 1'b0; eng_req_ready = 1'b1;
        eng_res_valid = 1'b0; eng_res_iter = '0; sx = '0; sy = '0; bram_rdata = '0;
        eng_auto = 1'b1; eng_cnt = 0; eng_iter_val = 9'd300;
        repeat (3) cycle();
        checks++; if ({eng_req_valid, bram_we, frame_done, c_change} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {eng_req_valid, bram_we, frame_done, c_change}); end
        checks++; if ({eng_x_com, eng_y_com} !== 64'h0) begin errors++; $display("FAIL reset_xy: got %h/%h want 0/0", eng_x_com, eng_y_com); end
        checks++; if ({bram_waddr, bram_wdata, zoom_level} !== 26'h0) begin errors++; $display("FAIL reset_bram_zoom: got %h %h %h want 0", bram_waddr, bram_wdata, zoom_level); end
        checks++; if ({o_red, o_green, o_blue} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h want 0", {o_red, o_green, o_blue}); end
        rst = 1'b1;
        cycle();
        checks++; if (eng_req_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", eng_req_valid); end
        checks++; if (eng_x_com !== 32'hFFFC_0000) begin errors++; $display("FAIL first_x: got %h want fffc0000", eng_x_com); end
        checks++; if (eng_y_com !== 32'h0002_4000) begin errors++; $display("FAIL first_y: got %h want 00024000", eng_y_com); end
    endtask

    task automatic test_frame();
        for (int i = 0; i < 400 && fd_count == 0; i++) cycle();
        checks++; if (fd_count != 1) begin errors++; $display("FAIL frame_done_seen: got %0d want 1", fd_count); end
        checks++; if (wr_count != H * V) begin errors++; $display("FAIL frame_writes: got %0d want %0d", wr_count, H * V); end
        checks++; if (f_count != H * V) begin errors++; $display("FAIL frame_wdata_F: got %0d want %0d", f_count, H * V); end
        checks++; if (seq_count != H * V) begin errors++; $display("FAIL frame_addr_seq: got %0d want %0d", seq_count, H * V); end
        cycle();
        checks++; if (fd_count != 1) begin errors++; $display("FAIL frame_done_pulse: got %0d want 1", fd_count); end
        for (int i = 0; i < 20 && hs_count <= H * V; i++) cycle();
        checks++; if (reqx[1] !== 32'hFFFD_2492) begin errors++; $display("FAIL x_step: got %h want fffd2492", reqx[1]); end
        checks++; if (reqx[7] !== 32'h0003_FFFE) begin errors++; $display("FAIL x_row_end: got %h want 0003fffe", reqx[7]); end
        checks++; if ({reqx[8], reqy[8]} !== {32'hFFFC_0000, 32'h0000_C000}) begin errors++; $display("FAIL row1_start: got %h/%h want fffc0000/0000c000", reqx[8], reqy[8]); end
        checks++; if (reqy[31] !== 32'hFFFD_C000) begin errors++; $display("FAIL last_row_y: got %h want fffdc000", reqy[31]); end
        checks++; if ({reqx[32], reqy[32]} !== {32'hFFFC_0000, 32'h0002_4000}) begin errors++; $display("FAIL frame_reload: got %h/%h want fffc0000/00024000", reqx[32], reqy[32]); end
    endtask

    task automatic test_quant_and_display();
        pixel_with(9'd0,   4'h0);
        pixel_with(9'd15,  4'h0);
        pixel_with(9'd16,  4'h1);
        pixel_with(9'd255, 4'hF);
        pixel_with(9'd256, 4'hF);
        sx = 16'd3; sy = 16'd2;
        #1;
        checks++; if (bram_raddr !== 20'd19) begin errors++; $display("FAIL raddr: got %0d want 19", bram_raddr); end
        sx = 16'd8; sy = 16'd0; bram_rdata = 4'h5; mode = 1'b0;
        #1;
        checks++; if (bram_raddr !== 20'd0) begin errors++; $display("FAIL raddr_oob: got %0d want 0", bram_raddr); end
        cycle(); cycle();
        checks++; if (o_red !== 8'h00) begin errors++; $display("FAIL rgb_oob: got %h want 00", o_red); end
        sx = 16'd0; sy = 16'd0;
        cycle();
        checks++; if (o_green !== 8'h00) begin errors++; $display("FAIL rgb_latency: got %h want 00 after 1 clk", o_green); end
        cycle();
        checks++; if ({o_red, o_green, o_blue} !== 24'h555555) begin errors++; $display("FAIL rgb_gray: got %h want 555555", {o_red, o_green, o_blue}); end
        mode = 1'b1;
        cycle(); cycle();
        checks++; if ({o_red, o_green, o_blue} !== 24'hAAAAAA) begin errors++; $display("FAIL rgb_invert: got %h want aaaaaa", {o_red, o_green, o_blue}); end
        sx = 16'd0; sy = 16'd4;
        cycle(); cycle();
        checks++; if (o_blue !== 8'h00) begin errors++; $display("FAIL rgb_oob_y: got %h want 00", o_blue); end
    endtask

    task automatic test_zoom();
        int base;
        pixel_with(9'd300, 4'hF);
        eng_auto = 1'b0; eng_cnt = 0; eng_res_valid = 1'b0;
        cycle();
        base = wr_count;
        btn[1] = 1'b0;
        repeat (3) cycle();
        eng_res_iter = 9'd100; eng_res_valid = 1'b1;
        cycle();
        eng_res_valid = 1'b0;
        btn = 7'h7F;
        checks++; if (wr_count != base) begin errors++; $display("FAIL restart_no_write: got %0d writes want 0", wr_count - base); end
        checks++; if ({eng_req_valid, eng_x_com, eng_y_com} !== {1'b1, 32'hFFFE_0000, 32'h0001_2000}) begin errors++; $display("FAIL zoom1_req: got %b %h %h want 1 fffe0000 00012000", eng_req_valid, eng_x_com, eng_y_com); end
        checks++; if (zoom_level !== 2'd1) begin errors++; $display("FAIL zoom1_level: got %0d want 1", zoom_level); end
        checks++; if (bram_waddr !== 20'd0) begin errors++; $display("FAIL restart_addr: got %0d want 0", bram_waddr); end
        repeat (4) press(1);
        checks++; if (zoom_level !== 2'd3) begin errors++; $display("FAIL zoom_sat: got %0d want 3", zoom_level); end
        flush();
        checks++; if ({last_req_x, last_req_y} !== {32'hFFFF_8000, 32'h0000_4800}) begin errors++; $display("FAIL zoom3_req: got %h/%h want ffff8000/00004800", last_req_x, last_req_y); end
    endtask

    task automatic test_pan();
        int base;
        repeat (3) press(2);
        checks++; if (zoom_level !== 2'd0) begin errors++; $display("FAIL zoom_out: got %0d want 0", zoom_level); end
        btn = 7'h7F & ~7'b000_1010;
        repeat (3) cycle();
        btn = 7'h7F;
        repeat (3) cycle();
        flush();
        checks++; if (zoom_level !== 2'd1) begin errors++; $display("FAIL prio_zoom: got %0d want 1", zoom_level); end
        checks++; if (last_req_x !== 32'hFFFE_0000) begin errors++; $display("FAIL prio_no_pan: got %h want fffe0000", last_req_x); end
        press(2);
        for (int i = 0; i < 40; i++) press(4);
        flush();
        checks++; if ({last_req_x, last_req_y} !== {32'h0000_0000, 32'h0002_4000}) begin errors++; $display("FAIL pan_clamp: got %h/%h want 00000000/00024000", last_req_x, last_req_y); end
        press(5);
        flush();
        checks++; if (last_req_y !== 32'h0002_D000) begin errors++; $display("FAIL pan_up: got %h want 0002d000", last_req_y); end
        base = cc_count;
        press(0);
        checks++; if (cc_count != base + 1) begin errors++; $display("FAIL c_change_pulse: got %0d cycles want 1", cc_count - base); end
        base = wr_count;
        flush();
        checks++; if (wr_count != base) begin errors++; $display("FAIL c_change_restart: got %0d writes want 0", wr_count - base); end
    endtask

    task automatic test_stall();
        int base, stable;
        eng_req_ready = 1'b0;
        eng_res_iter = 9'd100; eng_res_valid = 1'b1;
        cycle();
        eng_res_valid = 1'b0;
        checks++; if ({last_waddr, last_wdata} !== {20'd0, 4'h6}) begin errors++; $display("FAIL stall_prewrite: got %0d/%h want 0/6", last_waddr, last_wdata); end
        cycle();
        base = wr_count;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin eng_res_iter = 9'd50; eng_res_valid = 1'b1; end
            cycle();
            eng_res_valid = 1'b0;
            if (eng_req_valid === 1'b1 && eng_x_com === 32'h0001_2492 && eng_y_com === 32'h0002_D000) stable++;
        end
        checks++; if (stable != 10) begin errors++; $display("FAIL stall_hold: got %0d stable cycles want 10", stable); end
        checks++; if (wr_count != base) begin errors++; $display("FAIL stall_ignore_res: got %0d writes want 0", wr_count - base); end
        eng_req_ready = 1'b1;
        cycle();
        eng_res_iter = 9'd300; eng_res_valid = 1'b1;
        cycle();
        eng_res_valid = 1'b0;
        checks++; if ({last_waddr, last_wdata} !== {20'd1, 4'hF}) begin errors++; $display("FAIL stall_write: got %0d/%h want 1/f", last_waddr, last_wdata); end
    endtask

    task automatic test_async_reset();
        int base;
        cycle(); cycle();
        rst = 1'b0;
        #1;
        checks++; if ({eng_req_valid, bram_we, frame_done, c_change, zoom_level} !== 6'b0) begin errors++; $display("FAIL arst_ctrl: got %b want 0", {eng_req_valid, bram_we, frame_done, c_change, zoom_level}); end
        checks++; if ({eng_x_com, eng_y_com, bram_waddr, bram_wdata} !== 88'h0) begin errors++; $display("FAIL arst_data: got %h %h %h %h want 0", eng_x_com, eng_y_com, bram_waddr, bram_wdata); end
        checks++; if ({o_red, o_green, o_blue} !== 24'h0) begin errors++; $display("FAIL arst_rgb: got %h want 0", {o_red, o_green, o_blue}); end
        cycle(); cycle();
        eng_auto = 1'b1; eng_cnt = 0; eng_res_valid = 1'b0; eng_iter_val = 9'd300;
        rst = 1'b1;
        base = hs_count;
        for (int i = 0; i < 10 && hs_count == base; i++) cycle();
        checks++; if ({last_req_x, last_req_y} !== {32'hFFFC_0000, 32'h0002_4000}) begin errors++; $display("FAIL arst_first_req: got %h/%h want fffc0000/00024000", last_req_x, last_req_y); end
        base = wr_count;
        for (int i = 0; i < 20 && wr_count == base; i++) cycle();
        checks++; if ({last_waddr, last_wdata} !== {20'd0, 4'hF}) begin errors++; $display("FAIL arst_first_write: got %0d/%h want 0/f", last_waddr, last_wdata); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_quant_and_display();
        test_zoom();
        test_pan();
        test_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
